// File: rtl/pixel_fb_writer.sv
// pixel_fb_writer
//   Takes a stream of (x, y, colour) pixels from a shape generator that cannot
//   be stalled. It clips them against the framebuffer, buffers them in a small
//   FIFO and writes them to framebuffer memory through a req/ack port.
//   frame_done pulses once every accepted pixel of a shape has been written.
//
//   Build option: define FB_WRITER_RGB565_EN to store RGB565 in the low 16 bits
//   of mem_wdata. Otherwise mem_wdata carries the RGB888 colour unchanged.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   in_px, in_py        pixel coordinates (8 bits each)
//   in_color            RGB888 colour {R, G, B}
//   in_valid            pixel qualifier, sampled every rising edge
//   in_done             one-cycle end-of-shape pulse
//   mem_req/addr/wdata  write request, held stable until mem_ack
//   mem_ack             memory accepted the current request
//   busy                state machine not idle
//   frame_done          one-cycle pulse when the shape is fully written
//   overflow            sticky: an in-range pixel was dropped on a full FIFO
//   clip_count          saturating count of out-of-bounds pixels
module pixel_fb_writer #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_px,
  input  logic [7:0]        in_py,
  input  logic [23:0]       in_color,
  input  logic              in_valid,
  input  logic              in_done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [23:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic [15:0]       clip_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam int ENTRY_W = ADDR_W + 24;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  function automatic logic [23:0] pack_color(input logic [23:0] c);
`ifdef FB_WRITER_RGB565_EN
    return {8'h00, c[23:19], c[15:10], c[7:3]};
`else
    return c;
`endif
  endfunction

  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [7:0] x, input logic [7:0] y);
    logic [31:0] a;
    a = 32'(y) * 32'(FB_W) + 32'(x);
    return a[ADDR_W-1:0];
  endfunction

  function automatic logic out_of_bounds(input logic [7:0] x, input logic [7:0] y);
    return (32'(x) >= 32'(FB_W)) || (32'(y) >= 32'(FB_H));
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t state, state_nxt;

  logic              vld_p0;
  logic [7:0]        px_p0, py_p0;
  logic [23:0]       color_p0;
  logic              vld_p1, clip_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [23:0]       data_p1;

  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full, pop, push, in_range, drop;
  logic [ENTRY_W-1:0] head;

  // ---- stage p0: register raw input sample ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= in_valid;
  end

  always_ff @(posedge clk) begin
    px_p0    <= in_px;
    py_p0    <= in_py;
    color_p0 <= in_color;
  end

  // ---- stage p1: clip test, address and colour formatting ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      clip_p1 <= 1'b0;
    end else begin
      vld_p1  <= vld_p0;
      clip_p1 <= out_of_bounds(px_p0, py_p0);
    end
  end

  always_ff @(posedge clk) begin
    addr_p1 <= pixel_addr(px_p0, py_p0);
    data_p1 <= pack_color(color_p0);
  end

  // ---- stage p2: FIFO push; head of FIFO drives the memory port ----
  assign pop      = mem_req & mem_ack;
  assign full     = (count == FULL_CNT);
  assign in_range = vld_p1 & ~clip_p1;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = in_range & (~full | pop);
  assign drop     = in_range & full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      clip_count <= 16'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
      if (vld_p1 && clip_p1) clip_count <= sat_inc16(clip_count);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {addr_p1, data_p1};
  end

  assign head    = fifo_mem[rd_ptr];
  assign mem_req = (count != '0);
  // Gate the bus so it reads as zero whenever no request is presented,
  // including straight after reset when the storage holds stale data.
  assign mem_addr  = mem_req ? head[ENTRY_W-1:24] : '0;
  assign mem_wdata = mem_req ? head[23:0] : 24'd0;

  // ---- control FSM ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    frame_done = (state == DONE);
    case (state)
      IDLE: begin
        // A pixel arriving with in_done must still be drained, so go to FLUSH.
        if (in_valid && in_done) state_nxt = FLUSH;
        else if (in_valid)       state_nxt = RUN;
        else if (in_done)        state_nxt = DONE;
      end
      RUN: begin
        if (in_done) state_nxt = FLUSH;
      end
      FLUSH: begin
        // Pixels still in the input pipeline count as pending work.
        if (!in_valid && !vld_p0 && !vld_p1 && (count == '0)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pixel_fb_writer.sv
// tb_pixel_fb_writer
//   Scoreboard bench for pixel_fb_writer. Stimulus pushes the expected memory
//   writes into a queue; a monitor on the falling edge pops and compares each
//   accepted write, checks stall stability and frame_done completeness.
module tb_pixel_fb_writer;
  localparam int FB_W = 160;
  localparam int FB_H = 120;
  localparam int FIFO_DEPTH = 8;
  localparam int ADDR_W = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        in_px = '0;
  logic [7:0]        in_py = '0;
  logic [23:0]       in_color = '0;
  logic              in_valid = 1'b0;
  logic              in_done = 1'b0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [23:0]       mem_wdata;
  logic              mem_ack;
  logic              busy;
  logic              frame_done;
  logic              overflow;
  logic [15:0]       clip_count;

  always #5 clk = ~clk;

  pixel_fb_writer #(
    .FB_W(FB_W), .FB_H(FB_H), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_px(in_px), .in_py(in_py), .in_color(in_color),
    .in_valid(in_valid), .in_done(in_done),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .busy(busy), .frame_done(frame_done),
    .overflow(overflow), .clip_count(clip_count)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [23:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  exp_clip = 0;
  int  fd_count = 0;
  int  wr_count = 0;
  int  ack_mode = 0;   // 0: ack low, 1: ack high, 2: random

  function automatic logic [23:0] exp_data(input logic [23:0] c);
`ifdef FB_WRITER_RGB565_EN
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = 5'(c[23:16] / 8);
    g = 6'(c[15:8] / 4);
    b = 5'(c[7:0] / 8);
    return {8'h00, r, g, b};
`else
    return c;
`endif
  endfunction

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory acknowledge driver
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ack_mode)
        0:       mem_ack = 1'b0;
        1:       mem_ack = 1'b1;
        default: mem_ack = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor / scoreboard
  logic              stall_prev = 1'b0;
  logic [ADDR_W-1:0] addr_prev = '0;
  logic [23:0]       data_prev = '0;

  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("stall_req_held", mem_req, 1);
        check_eq("stall_addr_held", mem_addr, addr_prev);
        check_eq("stall_data_held", mem_wdata, data_prev);
      end
      if (mem_req && mem_ack) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d, expected no write", mem_addr);
        end else begin
          e = exp_q.pop_front();
          check_eq("write_addr", mem_addr, e.addr);
          check_eq("write_data", mem_wdata, e.data);
        end
      end
      if (frame_done) begin
        fd_count++;
        check_eq("pending_at_frame_done", exp_q.size(), 0);
      end
      stall_prev = mem_req && !mem_ack;
      addr_prev  = mem_addr;
      data_prev  = mem_wdata;
    end
  end

  // Drive one input cycle; record the expected effect in the model.
  task automatic put(input bit v, input int x, input int y, input logic [23:0] c,
                     input bit d, input bit exp_write);
    wr_t e;
    @(posedge clk);
    #1;
    in_valid = v;
    in_px    = x[7:0];
    in_py    = y[7:0];
    in_color = c;
    in_done  = d;
    if (v) begin
      if (x < FB_W && y < FB_H) begin
        if (exp_write) begin
          e.addr = ADDR_W'(y * FB_W + x);
          e.data = exp_data(c);
          exp_q.push_back(e);
        end
      end else if (exp_clip < 65535) begin
        exp_clip++;
      end
    end
  endtask

  task automatic put_idle();
    put(1'b0, 0, 0, 24'd0, 1'b0, 1'b0);
  endtask

  task automatic end_shape();
    put(1'b0, 0, 0, 24'd0, 1'b1, 1'b0);
    put_idle();
  endtask

  task automatic wait_frame(input string name, input int start);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (fd_count != start) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq({name, "_frame_done_seen"}, seen, 1);
    repeat (5) @(posedge clk);
    check_eq({name, "_frame_done_once"}, fd_count - start, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   fd0, w0, n, n_in, x, y;
    bit   merge;
    logic req_seen [1:4];
    logic [ADDR_W-1:0] addr3;
    logic [23:0] data3;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_clip_count", clip_count, 0);
    rst = 1'b0;

    // Single pixel, latency and single-cycle request
    ack_mode = 1;
    repeat (2) @(posedge clk);
    fd0 = fd_count;
    w0  = wr_count;
    put(1'b1, 3, 2, 24'hFF8000, 1'b0, 1'b1);
    put_idle();
    addr3 = '0;
    data3 = '0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      #1;
      req_seen[i] = mem_req;
      if (i == 3) begin
        addr3 = mem_addr;
        data3 = mem_wdata;
      end
    end
    check_eq("single_req_c1", req_seen[1], 0);
    check_eq("single_req_c2", req_seen[2], 0);
    check_eq("single_req_c3", req_seen[3], 1);
    check_eq("single_req_c4", req_seen[4], 0);
    check_eq("single_addr", addr3, 323);
    check_eq("single_data", data3, exp_data(24'hFF8000));
    end_shape();
    wait_frame("single", fd0);
    check_eq("single_writes", wr_count - w0, 1);

    // 3x3 filled burst at (10,10)
    fd0 = fd_count;
    w0  = wr_count;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++)
        put(1'b1, 10 + dx, 10 + dy, 24'($urandom), 1'b0, 1'b1);
    end_shape();
    wait_frame("burst3x3", fd0);
    check_eq("burst3x3_writes", wr_count - w0, 9);

    // Clipped pixels
    fd0 = fd_count;
    w0  = wr_count;
    put(1'b1, 160, 5, 24'h123456, 1'b0, 1'b1);
    put(1'b1, 5, 120, 24'h654321, 1'b0, 1'b1);
    end_shape();
    wait_frame("clip", fd0);
    check_eq("clip_writes", wr_count - w0, 0);
    check_eq("clip_count", clip_count, exp_clip);
    check_eq("clip_overflow", overflow, 0);

    // Empty shape
    w0 = wr_count;
    put(1'b0, 0, 0, 24'd0, 1'b1, 1'b0);
    put_idle();
    @(negedge clk);
    #1;
    check_eq("empty_frame_done_c1", frame_done, 1);
    @(negedge clk);
    #1;
    check_eq("empty_frame_done_c2", frame_done, 0);
    repeat (4) @(posedge clk);
    check_eq("empty_writes", wr_count - w0, 0);

    // Stalled memory during a 12-pixel burst
    ack_mode = 0;
    repeat (2) @(posedge clk);
    fd0 = fd_count;
    w0  = wr_count;
    for (int i = 0; i < 12; i++)
      put(1'b1, 20 + i, 50, 24'($urandom), 1'b0, i < FIFO_DEPTH);
    put_idle();
    repeat (7) @(posedge clk);
    #1;
    check_eq("stall_overflow", overflow, 1);
    check_eq("stall_req_pending", mem_req, 1);
    check_eq("stall_no_writes", wr_count - w0, 0);
    ack_mode = 1;
    end_shape();
    wait_frame("stall", fd0);
    check_eq("stall_writes", wr_count - w0, FIFO_DEPTH);

    // Random shapes with random acknowledge
    ack_mode = 2;
    for (int f = 0; f < 25; f++) begin
      fd0   = fd_count;
      w0    = wr_count;
      n     = $urandom_range(0, FIFO_DEPTH);
      merge = $urandom_range(0, 1);
      n_in  = 0;
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 2)) put_idle();
        x = $urandom_range(0, 175);
        y = $urandom_range(0, 130);
        if (x < FB_W && y < FB_H) n_in++;
        put(1'b1, x, y, 24'($urandom), merge && (k == n - 1), 1'b1);
      end
      if (n == 0 || !merge) put(1'b0, 0, 0, 24'd0, 1'b1, 1'b0);
      put_idle();
      wait_frame("random", fd0);
      check_eq("random_writes", wr_count - w0, n_in);
      check_eq("random_clip_count", clip_count, exp_clip);
    end
    check_eq("overflow_sticky", overflow, 1);

    // Reset in the middle of a stalled burst
    ack_mode = 0;
    for (int i = 0; i < 5; i++)
      put(1'b1, 40 + i, 7, 24'($urandom), 1'b0, 1'b0);
    put_idle();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (mem_req) break;
    end
    check_eq("midrst_req_before", mem_req, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_mem_req", mem_req, 0);
    check_eq("midrst_mem_addr", mem_addr, 0);
    check_eq("midrst_mem_wdata", mem_wdata, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_frame_done", frame_done, 0);
    check_eq("midrst_overflow", overflow, 0);
    check_eq("midrst_clip_count", clip_count, 0);
    exp_q.delete();
    exp_clip = 0;
    ack_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    fd0 = fd_count;
    w0  = wr_count;
    put(1'b1, 3, 2, 24'hFF8000, 1'b0, 1'b1);
    end_shape();
    wait_frame("after_rst", fd0);
    check_eq("after_rst_writes", wr_count - w0, 1);
    check_eq("after_rst_overflow", overflow, 0);
    check_eq("after_rst_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_fb_writer.md
PIXEL_FB_WRITER -- requirements
Module: pixel_fb_writer

Interface
REQ-001 The block SHALL have these parameters (one per line: name, default, meaning):
- FB_W, 160, framebuffer width in pixels
- FB_H, 120, framebuffer height in pixels
- FIFO_DEPTH, 8, pixel buffer entries (power of two)
- ADDR_W, 15, memory address width

REQ-002 The block SHALL have these ports (one per line: name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_px  in  8  incoming pixel x
- in_py  in  8  incoming pixel y
- in_color  in  24  incoming RGB888 colour
- in_valid  in  1  pixel qualifier; no backpressure exists upstream
- in_done  in  1  one-cycle end-of-shape pulse from the pixel generator
- mem_req  out  1  write request to framebuffer memory
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  24  write data
- mem_ack  in  1  memory accepted the current request
- busy  out  1  high whenever state is not IDLE
- frame_done  out  1  one-cycle pulse when all accepted pixels are written
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full
- clip_count  out  16  saturating count of out-of-bounds pixels dropped

Function
REQ-003 A pixel is sampled on every rising clk edge with in_valid=1; the block never stalls its input.
REQ-004 Clipping: a pixel with in_px>=FB_W or in_py>=FB_H SHALL be dropped; clip_count increments and saturates at 16'hFFFF.
REQ-005 In-range pixels SHALL be pushed into the FIFO with address in_py*FB_W+in_px (truncated to ADDR_W) and colour data per REQ-014.
REQ-006 When the FIFO is full and no pop occurs in the same cycle, an in-range pixel SHALL be dropped and overflow set; a push and a pop in the same cycle while full SHALL both succeed.
REQ-007 Latency: with the FIFO empty and no request outstanding, mem_req SHALL assert 2 cycles after the in_valid sample edge.
REQ-008 mem_req, mem_addr and mem_wdata SHALL stay stable while mem_req=1 and mem_ack=0.
REQ-009 The FIFO SHALL pop on each cycle with mem_req=1 and mem_ack=1. mem_req SHALL then present the next entry on the following cycle if one exists, giving one write per cycle back-to-back; otherwise mem_req SHALL drop.
REQ-010 Memory writes SHALL occur in input order.
REQ-011 The state machine SHALL have these states and transitions:
- IDLE -> RUN on in_valid.
- IDLE -> DONE on in_done without in_valid (empty shape).
- RUN -> FLUSH on in_done.
- FLUSH -> DONE when the FIFO is empty and mem_req=0.
- DONE -> IDLE unconditionally; frame_done=1 for exactly the DONE cycle.
REQ-012 in_valid during FLUSH SHALL still be accepted, and the pixel SHALL be written before frame_done. in_done during FLUSH or DONE SHALL be ignored.
REQ-013 in_valid and in_done in the same cycle: the pixel SHALL be accepted and the state SHALL advance as for in_done.

Reset
REQ-014 The colour format SHALL be set by REQ-017; with the macro undefined, mem_wdata SHALL equal in_color.
REQ-015 On rst=1 the block SHALL:
- set mem_req=0, mem_addr=0, mem_wdata=0, busy=0, frame_done=0, overflow=0, clip_count=0;
- empty the FIFO;
- set state to IDLE.
REQ-016 Reset asserted mid-frame SHALL discard buffered pixels and abandon any outstanding request without waiting for mem_ack. overflow and clip_count SHALL clear only on rst.

Configuration
REQ-017 Macro FB_WRITER_RGB565_EN controls the stored colour format:
- Defined: mem_wdata = {8'h00, R[7:3], G[7:2], B[7:3]}, where in_color = {R, G, B}.
- Undefined: mem_wdata carries the full RGB888 value unchanged.
- The port width is 24 in both cases.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Single pixel (3,2), colour 24'hFF8000, mem_ack tied 1 -> mem_req high for exactly one cycle, 2 cycles after the sample edge, with mem_addr=323.
- 3x3 filled burst at (10,10), mem_ack=1, then in_done -> 9 writes in order (addresses 1610, 1611, 1612, 1770, ...); frame_done pulses once after the last write.
- Pixel (160,5) and pixel (5,120) -> no writes; clip_count=2; frame_done still pulses after in_done.
- mem_ack held 0 for 20 cycles during a 12-pixel burst -> exactly 8 pixels written after ack resumes; overflow=1; request signals stable while stalled.
- in_done with no pixels -> frame_done high in the cycle after the in_done edge; no mem_req.
- rst asserted mid-burst with mem_req=1 -> all outputs 0 immediately; the next frame starts cleanly; with FB_WRITER_RGB565_EN, colour 24'hFF8000 writes mem_wdata 24'h00FC00.
